// File: rtl/uart_pkg.sv
// Shared UART datapath definitions: default word geometry, the buffered
// word type, FIFO operation codes and the pointer-width helper.
package uart_pkg;

  localparam int unsigned DEFAULT_BITS_PER_WORD = 8;
  localparam int unsigned DEFAULT_W_OUT         = 16;
  localparam int unsigned DEFAULT_NUM_WORDS     = DEFAULT_W_OUT / DEFAULT_BITS_PER_WORD;

  // Character 0 sits in the low slot.
  typedef logic [DEFAULT_NUM_WORDS-1:0][DEFAULT_BITS_PER_WORD-1:0] uart_word_t;

  // What the FIFO does to its occupancy on a given edge.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // Address width for a power-of-two depth; never below one bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Word storage for the UART TX FIFO: synchronous write port, asynchronous
// read port. Contents are intentionally not reset.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W_OUT = DEFAULT_W_OUT,
  localparam int unsigned AW   = ptr_w(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [W_OUT-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [W_OUT-1:0] o_rdata
);

  logic [W_OUT-1:0] r_mem [DEPTH];

  // Write the incoming word on an accepted push.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Head word falls through combinationally.
  always_comb begin
    o_rdata = r_mem[i_raddr];
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through word FIFO feeding the UART transmitter.
// Optional occupancy outputs (level, almost_full) are built only when the
// macro UART_TX_FIFO_LEVEL_EN is defined.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned BITS_PER_WORD = DEFAULT_BITS_PER_WORD,
  parameter int unsigned W_OUT         = DEFAULT_W_OUT,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned AFULL_THRESH  = 12,
  localparam int unsigned NUM_WORDS    = W_OUT / BITS_PER_WORD,
  localparam int unsigned PW           = ptr_w(DEPTH),
  localparam int unsigned CW           = PW + 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    s_valid,
  output logic                                    s_ready,
  input  logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0] s_data,
  output logic                                    m_valid,
  input  logic                                    m_ready,
  output logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0] m_data
`ifdef UART_TX_FIFO_LEVEL_EN
  ,
  output logic [CW-1:0]                           level,
  output logic                                    almost_full
`endif
);

  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_THRESH);

  // Reject illegal geometries at elaboration.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of two >= 2");
  end
  if ((W_OUT % BITS_PER_WORD) != 0) begin : g_bad_width
    $error("uart_tx_fifo: W_OUT must be a multiple of BITS_PER_WORD");
  end
  if (AFULL_THRESH > DEPTH) begin : g_bad_thresh
    $error("uart_tx_fifo: AFULL_THRESH exceeds DEPTH");
  end

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  logic             w_push;
  logic             w_pop;
  logic             w_s_ready;
  logic             w_m_valid;
  logic [W_OUT-1:0] w_rd_word;
  fifo_op_e         w_op;

  // Handshake qualifiers from registered state only; no m_ready->s_ready path.
  always_comb begin
    w_s_ready = (r_count != FULL_CNT) && !rst;
    w_m_valid = (r_count != '0);
    w_push    = s_valid && w_s_ready;
    w_pop     = w_m_valid && m_ready;
  end

  // Classify the edge and derive the next occupancy.
  always_comb begin
    w_op        = OP_IDLE;
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_op = OP_PUSH;
      2'b01:   w_op = OP_POP;
      2'b11:   w_op = OP_BOTH;
      default: w_op = OP_IDLE;
    endcase
    case (w_op)
      OP_PUSH: w_count_nxt = r_count + CW'(1);
      OP_POP:  w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointer and occupancy registers; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .W_OUT (W_OUT)
  ) u_mem (
    .i_clk   (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (s_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_word)
  );

  assign s_ready = w_s_ready;
  assign m_valid = w_m_valid;
  assign m_data  = w_rd_word;

`ifdef UART_TX_FIFO_LEVEL_EN
  logic [CW-1:0] r_level;
  logic          r_afull;

  // Occupancy outputs load from the next count so they move with r_count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_level <= '0;
      r_afull <= 1'b0;
    end else begin
      r_level <= w_count_nxt;
      r_afull <= (w_count_nxt >= AFULL_CNT);
    end
  end

  assign level       = r_level;
  assign almost_full = r_afull;
`endif

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Synchronous word FIFO that sits directly upstream of the UART transmitter. It accepts multi-byte words from a producer with a valid/ready handshake and buffers them while the transmitter is busy serialising. It presents them to the transmitter's `s_valid`/`s_data`/`s_ready` port in first-word-fall-through order. This decouples bursty producers from the slow serial line without dropping words.

## Interface
Parameters:
- `BITS_PER_WORD`, 8: bits per serial character.
- `W_OUT`, 16: bits per buffered word. Must be a multiple of `BITS_PER_WORD`.
- `DEPTH`, 16: number of word entries. Must be a power of two, ≥ 2.
- `AFULL_THRESH`, 12: level at or above which `almost_full` asserts. Only used with the level feature; see Configuration.
- `NUM_WORDS`, `W_OUT/BITS_PER_WORD`: localparam.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `s_valid` in 1: producer word valid.
- `s_ready` out 1: FIFO can accept a word.
- `s_data` in `[NUM_WORDS-1:0][BITS_PER_WORD-1:0]`: producer word, character 0 in the low slot.
- `m_valid` out 1: head word valid, to the transmitter's `s_valid`.
- `m_ready` in 1: transmitter accepts the head word, from the transmitter's `s_ready`.
- `m_data` out `[NUM_WORDS-1:0][BITS_PER_WORD-1:0]`: head word, to the transmitter's `s_data`.
- `level` out `$clog2(DEPTH)+1`: present only with `UART_TX_FIFO_LEVEL_EN`.
- `almost_full` out 1: present only with `UART_TX_FIFO_LEVEL_EN`.

## Operation
- State:
  - write pointer `wr_ptr` and read pointer `rd_ptr`, each `$clog2(DEPTH)` bits;
  - occupancy `count`, `$clog2(DEPTH)+1` bits;
  - storage array of `DEPTH` × `W_OUT`.
- Push occurs when `s_valid && s_ready`:
  - write `s_data` at `wr_ptr`;
  - `wr_ptr` increments and wraps from `DEPTH-1` to 0.
- Pop occurs when `m_valid && m_ready`:
  - `rd_ptr` increments, with the same wrap.
- Count update: push only gives +1, pop only gives −1, both or neither gives unchanged.
- `s_ready = (count != DEPTH) && !rst`. It depends only on registered state; there is no combinational path from `m_ready` to `s_ready`. When full, a push is refused even in a cycle where a pop occurs.
- `m_valid = (count != 0)`. `m_data` is an asynchronous read of the array at `rd_ptr`, so the head word falls through.
- Once `m_valid` is high, `m_data` stays stable until it is popped, even while pushes continue.
- Push and pop in the same cycle with `0 < count < DEPTH`: both take effect and `count` is unchanged.
- Push when empty: the word appears at the output on the next cycle; the same-cycle bypass to the output is not implemented.
- Reset:
  - clears `wr_ptr`, `rd_ptr` and `count` to 0;
  - storage contents are not cleared.
- Reset asserted mid-operation discards all buffered words. The transmitter may be mid-character; that character completes on its own, because the transmitter has already latched it.

## Timing
- Reset values (the cycle after `rst` is sampled high):
  - `m_valid` = 0, `count` = 0;
  - `s_ready` = 0 while `rst` is high, and 1 in the first cycle after release;
  - `level` = 0, `almost_full` = 0.
- Latency from the push edge to `m_valid` is 1 cycle when the FIFO is empty.
- Throughput is one push and one pop per cycle.
- Ready rises 1 cycle after the pop that leaves a free slot.

## Configuration
- `UART_TX_FIFO_LEVEL_EN` defined:
  - the `level` and `almost_full` ports exist;
  - `level` = `count`, registered;
  - `almost_full = (count >= AFULL_THRESH)`, registered, updated on the same edge as `count`.
- `UART_TX_FIFO_LEVEL_EN` undefined: the ports and threshold logic are absent and FIFO behaviour is otherwise identical.

## Structure
- Shared package `uart_pkg`:
  - `BITS_PER_WORD` and `W_OUT` defaults;
  - typedef `uart_word_t` (the packed `[NUM_WORDS-1:0][BITS_PER_WORD-1:0]`);
  - a `ptr_w(depth)` helper constant function.
- Sub-module `uart_fifo_mem`: a `DEPTH` × `W_OUT` array with a synchronous write port and an asynchronous read port. Pointer and count control remain in `uart_tx_fifo`.

## Test plan
- Reset, then idle → `m_valid`=0, `s_ready`=1, `level`=0.
- Push `16'hA55A` into an empty FIFO with `m_ready`=0 → `m_valid`=1 next cycle, `m_data`=`16'hA55A`, `level`=1.
- Push 16 words `0x0000..0x000F` with `m_ready`=0 → `s_ready`=0 after the 16th word, and a 17th `s_valid` is ignored. `almost_full`=1 from `level`=12.
- Full FIFO, `s_valid`=1 and `m_ready`=1 in the same cycle → pop only, `level` goes 16 → 15. Push is accepted next cycle, and data comes out in order `0x0000, 0x0001, …` with no loss.
- Continuous push/pop of an incrementing pattern across more than 3 × `DEPTH` words → the pointers wrap and the output sequence matches the input exactly.
- 5 words buffered, `rst` pulsed for 1 cycle mid-pop → `m_valid`=0 next cycle and `level`=0. Stale words never reappear after new pushes.
